// File: rtl/rr_stage.sv
// Register-read stage: 8x16 register file, operand select with forwarding, load-use bubbles, RR/EX register.
// Optional macro RR_RF_BYPASS_EN enables same-cycle WB write-through to the operand read.
module rr_stage #(
  parameter int          DW        = 16,
  parameter int          AW        = 3,
  parameter logic [3:0]  BUBBLE_OP = 4'b1111
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rr_valid,
  input  logic [3:0]    rr_opcode,
  input  logic [1:0]    rr_cond,
  input  logic [AW-1:0] rr_ra,
  input  logic [AW-1:0] rr_rb,
  input  logic [AW-1:0] rr_waddr,
  input  logic [DW-1:0] rr_imm,
  input  logic [DW-1:0] rr_pc,
  input  logic          flush,
  output logic [AW-1:0] raddr_a,
  output logic [AW-1:0] raddr_b,
  input  logic          fwd_a,
  input  logic          fwd_b,
  input  logic [DW-1:0] fwd_data_a,
  input  logic [DW-1:0] fwd_data_b,
  input  logic          fwd_stall_a,
  input  logic          fwd_stall_b,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic          stall_o,
  output logic          ex_valid,
  output logic [3:0]    ex_opcode,
  output logic [1:0]    ex_cond,
  output logic [AW-1:0] ex_waddr,
  output logic [DW-1:0] ex_opa,
  output logic [DW-1:0] ex_opb,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc
);

  localparam int NREG = 2**AW;

  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] rf_a_p0, rf_b_p0;
  logic [DW-1:0] opa_p0, opb_p0;
  logic          load_p0;

  assign raddr_a = rr_ra;
  assign raddr_b = rr_rb;

  assign stall_o = rr_valid & (fwd_stall_a | fwd_stall_b) & ~flush;
  assign load_p0 = rr_valid & ~stall_o & ~flush;

  always_comb begin
    rf_a_p0 = rf[rr_ra];
    rf_b_p0 = rf[rr_rb];
`ifdef RR_RF_BYPASS_EN
    if (wb_we && (wb_waddr == rr_ra)) rf_a_p0 = wb_wdata;
    if (wb_we && (wb_waddr == rr_rb)) rf_b_p0 = wb_wdata;
`endif
    // The forward mux keeps an undriven fwd_data off the path when fwd is low.
    opa_p0 = fwd_a ? fwd_data_a : rf_a_p0;
    opb_p0 = fwd_b ? fwd_data_b : rf_b_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end

  // ---- RR/EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_opcode <= BUBBLE_OP;
      ex_cond   <= '0;
      ex_waddr  <= '0;
      ex_opa    <= '0;
      ex_opb    <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else if (load_p0) begin
      ex_valid  <= 1'b1;
      ex_opcode <= rr_opcode;
      ex_cond   <= rr_cond;
      ex_waddr  <= rr_waddr;
      ex_opa    <= opa_p0;
      ex_opb    <= opb_p0;
      ex_imm    <= rr_imm;
      ex_pc     <= rr_pc;
    end else begin
      ex_valid  <= 1'b0;
      ex_opcode <= BUBBLE_OP;
    end
  end

endmodule
